// File: rtl/decoder_38_stream.sv
// decoder_38_stream
//   Registered 3-to-8 one-hot decoder with valid/ready flow control.
//   A code {a,b,c} is buffered in a small FIFO. The head entry is
//   presented on y as a one-hot byte. A built-in scan sequencer can
//   push codes 0..7 without an external driver, for encoder/decoder
//   loopback self-test.
//
// Parameters:
//   FIFO_DEPTH - code buffer entries (power of two, >= 2)
//   SCAN_GAP   - idle cycles after each scan push (0..15)
//
// Ports:
//   clk, rst           - clock (rising edge), synchronous active-high reset
//   a, b, c            - code bits, weights 4/2/1
//   in_valid/in_ready  - input handshake
//   y                  - decoded one-hot of the FIFO head
//   out_valid/out_ready- output handshake
//   scan_start         - one-cycle request to scan codes 0..7
//   scan_busy          - scan sequencer active
//   scan_done          - one-cycle pulse after scan code 7 is pushed
//
// Build option:
//   DEC38_ACTIVE_LOW_EN - y is active-low (74138 style): the selected bit
//                         is 0, the others are 1, and y is 8'hFF when idle.

module decoder_38_stream #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned SCAN_GAP   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] y,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       scan_start,
    output logic       scan_busy,
    output logic       scan_done
);

    localparam int unsigned AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);
    localparam logic [3:0]  GAP_RELOAD = 4'(SCAN_GAP);

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [2:0]  scan_cnt_q, scan_cnt_d;
    logic [3:0]  gap_q, gap_d;
    logic        scan_done_q, scan_done_d;

    // Pointers carry one extra bit so full and empty can be told apart
    // when the index bits are equal.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]  mem_q [FIFO_DEPTH];
    logic [2:0]  mem_d [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------
    logic       empty;
    logic       full;
    logic       ext_push;
    logic       scan_push;
    logic       push;
    logic       pop;
    logic [2:0] wr_data;
    logic [2:0] head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Depends only on registered state (and rst), so a pop in the same
    // cycle cannot open the input while the buffer is full.
    assign in_ready = !full && (state_q == ST_IDLE) && !rst;

    assign ext_push = in_valid && in_ready;
    assign pop      = !empty && out_ready;
    assign push     = ext_push || scan_push;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];

    // ------------------------------------------------------------------
    // Scan sequencer next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        scan_cnt_d  = scan_cnt_q;
        gap_d       = gap_q;
        scan_done_d = 1'b0;
        scan_push   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (scan_start) begin
                    state_d    = ST_SCAN;
                    scan_cnt_d = 3'd0;
                    gap_d      = 4'd0;
                end
            end

            ST_SCAN: begin
                if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else if (!full) begin
                    // A full buffer simply holds the counter, so no code
                    // is ever skipped under backpressure.
                    scan_push  = 1'b1;
                    gap_d      = GAP_RELOAD;
                    scan_cnt_d = scan_cnt_q + 3'd1;
                    if (scan_cnt_q == 3'd7) begin
                        state_d     = ST_IDLE;
                        scan_done_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_data = scan_push ? scan_cnt_q : {a, b, c};
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            scan_cnt_q  <= 3'd0;
            gap_q       <= 4'd0;
            scan_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            scan_cnt_q  <= scan_cnt_d;
            gap_q       <= gap_d;
            scan_done_q <= scan_done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between the
    // pointers, which are reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = !empty;
    assign scan_busy = (state_q == ST_SCAN);
    assign scan_done = scan_done_q;

    always_comb begin
`ifdef DEC38_ACTIVE_LOW_EN
        y = '1;
        if (!empty) begin
            y[head] = 1'b0;
        end
`else
        y = '0;
        if (!empty) begin
            y[head] = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_decoder_38_stream.sv
module tb_decoder_38_stream;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned GAP   = 0;

`ifdef DEC38_ACTIVE_LOW_EN
    localparam logic [7:0] Y_IDLE = 8'hFF;
`else
    localparam logic [7:0] Y_IDLE = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       a, b, c;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] y;
    logic       out_valid;
    logic       out_ready;
    logic       scan_start;
    logic       scan_busy;
    logic       scan_done;

    always #5 clk = ~clk;

    decoder_38_stream #(
        .FIFO_DEPTH (DEPTH),
        .SCAN_GAP   (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .c          (c),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .y          (y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .scan_start (scan_start),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] enc(input int unsigned code);
        logic [7:0] v;
        logic [2:0] idx;
        idx    = code[2:0];
        v      = '0;
        v[idx] = 1'b1;
`ifdef DEC38_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    // ------------------------------------------------------------------
    // Reference model + scoreboard, evaluated on the falling edge with
    // the inputs that will be sampled on the next rising edge.
    // ------------------------------------------------------------------
    logic [7:0]  sb [$];
    bit          mon_en = 0;
    int unsigned m_occ  = 0;
    bit          m_scan = 0;
    bit          m_done = 0;
    int unsigned m_code = 0;
    int unsigned m_gap  = 0;
    int unsigned pops   = 0;
    bit          exp_ir, m_pop, m_epush, m_spush;
    logic [7:0]  exp_y;

    always @(negedge clk) begin
        exp_ir = !rst && (m_occ < DEPTH) && !m_scan;
        if (mon_en) begin
            check_eq("in_ready",  in_ready,  exp_ir);
            check_eq("out_valid", out_valid, m_occ != 0);
            check_eq("scan_busy", scan_busy, m_scan);
            check_eq("scan_done", scan_done, m_done);
            if (!out_valid)
                check_eq("y_idle", y, Y_IDLE);
            else
                check_eq("y_onehot", $countones(y ^ Y_IDLE), 1);
        end
        if (rst) begin
            sb.delete();
            m_occ  = 0;
            m_scan = 0;
            m_done = 0;
            m_code = 0;
            m_gap  = 0;
            mon_en = 1;
        end else begin
            m_pop   = (m_occ != 0) && out_ready;
            m_epush = in_valid && exp_ir;
            m_spush = m_scan && (m_gap == 0) && (m_occ < DEPTH);
            if (m_pop) begin
                if (sb.size() != 0) begin
                    exp_y = sb.pop_front();
                    check_eq("y_order", y, exp_y);
                end else begin
                    check_eq("sb_nonempty", sb.size(), 1);
                end
                pops++;
            end
            if (m_epush) sb.push_back(enc({29'd0, a, b, c}));
            if (m_spush) sb.push_back(enc(m_code));
            m_occ  = m_occ + ((m_epush || m_spush) ? 1 : 0) - (m_pop ? 1 : 0);
            m_done = m_spush && (m_code == 7);
            if (m_scan) begin
                if (m_spush) begin
                    m_gap = GAP;
                    if (m_code == 7) begin
                        m_scan = 0;
                        m_code = 0;
                    end else begin
                        m_code++;
                    end
                end else if (m_gap != 0) begin
                    m_gap--;
                end
            end else if (scan_start) begin
                m_scan = 1;
                m_code = 0;
                m_gap  = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_code(input int unsigned code);
        logic [2:0] v;
        v = code[2:0];
        {a, b, c} = v;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "global timeout");
    end

    int unsigned pops0;
    int unsigned done_seen;
    bit          finished;

    initial begin
        rst = 1'b1; a = 1'b0; b = 1'b0; c = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; scan_start = 1'b0;

        // Reset
        tick();
        tick();
        check_eq("rst_y",         y,         Y_IDLE);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready",  in_ready,  0);
        check_eq("rst_scan_busy", scan_busy, 0);
        rst = 1'b0;
        #1;
        check_eq("in_ready_after_rst", in_ready, 1);

        // Single code 5
        out_ready = 1'b1;
        set_code(5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("single_valid", out_valid, 1);
        check_eq("single_y",     y,         enc(5));
        tick();
        check_eq("single_drain", out_valid, 0);

        // All codes back-to-back
        for (int unsigned i = 0; i < 8; i++) begin
            set_code(i);
            in_valid = 1'b1;
            tick();
            check_eq("seq_valid", out_valid, 1);
            check_eq("seq_y",     y,         enc(i));
        end
        in_valid = 1'b0;
        tick();
        check_eq("seq_drain", out_valid, 0);

        // Backpressure
        out_ready = 1'b0;
        set_code(3); in_valid = 1'b1; tick();
        set_code(6); tick();
        check_eq("bp_full_in_ready", in_ready, 0);
        set_code(1); tick();
        in_valid = 1'b0;
        check_eq("bp_head", y, enc(3));
        out_ready = 1'b1;
        #1;
        check_eq("bp_in_ready_pop_cycle", in_ready, 0);
        tick();
        check_eq("bp_in_ready_after_pop", in_ready, 1);
        check_eq("bp_second", y, enc(6));
        tick();
        check_eq("bp_drain", out_valid, 0);

        // Scan with alternating backpressure
        pops0 = pops;
        done_seen = 0;
        finished = 0;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        check_eq("scan_busy_start", scan_busy, 1);
        for (int unsigned cyc = 0; cyc < 200; cyc++) begin
            out_ready  = ~out_ready;
            scan_start = (cyc == 3);
            tick();
            if (scan_busy) check_eq("scan_in_ready", in_ready, 0);
            if (scan_done) done_seen++;
            if (done_seen != 0 && !out_valid) begin
                finished = 1;
                break;
            end
        end
        scan_start = 1'b0;
        out_ready  = 1'b1;
        check_eq("scan_finished",  finished,     1);
        check_eq("scan_done_once", done_seen,    1);
        check_eq("scan_pop_count", pops - pops0, 8);
        check_eq("scan_sb_empty",  sb.size(),    0);

        // Reset in the middle of a scan
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_scan_busy", scan_busy, 0);
        check_eq("midrst_scan_done", scan_done, 0);
        rst = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
            check_eq("midrst_no_done", scan_done, 0);
        end
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int unsigned k = 0; k < 10; k++) begin
            if (out_valid) break;
            tick();
        end
        check_eq("restart_valid", out_valid, 1);
        check_eq("restart_first", y,         enc(0));
        finished = 0;
        for (int unsigned k = 0; k < 60; k++) begin
            tick();
            if (!scan_busy && !out_valid) begin
                finished = 1;
                break;
            end
        end
        check_eq("restart_finished", finished, 1);

        // Idle value after everything drained
        tick();
        check_eq("final_idle_y", y, Y_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_38_stream.md
Name: decoder_38_stream

Overview:
- Registered 3-to-8 one-hot decoder with valid/ready flow control; the receive-side counterpart of the team's 8-to-3 encoder.
- Takes a 3-bit code on separate bits a/b/c and buffers it in a small FIFO. Emits the one-hot byte with a valid/ready handshake.
- A built-in scan sequencer can generate codes 0..7 on its own. This gives encoder/decoder loopback self-test without an external driver.

Parameters:
- FIFO_DEPTH, 2, entries in the code buffer; must be a power of two and at least 2.
- SCAN_GAP, 0, idle cycles inserted after each scan push; range 0..15.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- a  input  1  code MSB (weight 4).
- b  input  1  code middle bit (weight 2).
- c  input  1  code LSB (weight 1).
- in_valid  input  1  a/b/c hold a code to accept.
- in_ready  output  1  block can accept a code this cycle.
- y  output  8  decoded one-hot, y[4a+2b+c] set.
- out_valid  output  1  y is valid.
- out_ready  input  1  consumer takes y this cycle.
- scan_start  input  1  single-cycle request to run a scan of codes 0..7.
- scan_busy  output  1  scan sequencer active.
- scan_done  output  1  one-cycle pulse after scan code 7 is pushed.

Behaviour:
- Reset (rst high at a clk edge) values:
  - FIFO empty, out_valid=0, y=8'h00, in_ready=0 during reset.
  - scan_busy=0, scan_done=0, FSM=IDLE, scan counter=0, gap counter=0.
  - Reset mid-scan or with FIFO contents discards everything.
- Push/pop rules:
  - Push occurs when in_valid && in_ready at the clk edge; the stored code is {a,b,c}.
  - in_ready = !full && state==IDLE && !rst.
  - Pop occurs when out_valid && out_ready.
- Output:
  - out_valid = !empty.
  - y = one-hot of head code when out_valid=1, else 8'h00.
  - Exactly one bit of y is set whenever out_valid=1.
- Latency: a code pushed into an empty FIFO appears on y/out_valid in the next cycle. No combinational path from in_* to out_*.
- Full FIFO: in_ready=0. A pop in the same cycle does not enable a push; in_ready rises the cycle after the pop.
- Empty FIFO: a pop cannot occur; out_ready is ignored.
- Simultaneous push and pop on a non-full, non-empty FIFO: the count is unchanged and order is preserved (FIFO order always holds).
- Pointers: read and write pointers wrap modulo FIFO_DEPTH. Full/empty use an extra pointer bit.
- FSM states:
  - IDLE: scan_start=1 -> SCAN, counter=0, scan_busy=1 from the next cycle. Any in_valid in the scan_start cycle is still accepted if in_ready=1.
  - SCAN:
    - in_ready forced 0; in_valid and scan_start are ignored.
    - Each cycle the gap counter is 0 and the FIFO is not full, push the counter value. The gap counter then reloads SCAN_GAP and counter increments.
    - The gap counter decrements while nonzero.
    - Backpressure stalls the sequence without skipping codes.
    - The cycle code 7 is pushed: next state IDLE, scan_done=1 for exactly the following cycle, scan_busy=0 from that cycle.
  - scan_done never coincides with scan_busy=1.
- out_valid, y and scan_done come from registers or a FIFO head read.

Optional Feature:
- Macro DEC38_ACTIVE_LOW_EN.
- Defined:
  - y is inverted, 74138 style: the selected bit is 0 and the others are 1.
  - y=8'hFF when out_valid=0 and during reset.
  - Handshake and timing are unchanged.
- Undefined: active-high y as specified above.

Test Plan:
- Reset then single code:
  - rst high 2 cycles; check y=8'h00, out_valid=0, in_ready=0.
  - Release rst, push a=1 b=0 c=1 with out_ready=1 -> next cycle out_valid=1, y=8'h20, then out_valid=0.
- All codes: push codes 0..7 back-to-back with out_ready=1 -> y sequence 01,02,04,08,10,20,40,80 on 8 consecutive cycles.
- Backpressure:
  - out_ready=0, push codes 3,6,1 -> only 3 and 6 accepted; in_ready=0 after the second push.
  - Raise out_ready -> y=08 then 40; in_ready returns the cycle after the first pop.
- Scan with stalls:
  - SCAN_GAP=0, pulse scan_start, toggle out_ready 1/0 each cycle.
  - Expect y one-hots 01..80 in order with none skipped; in_ready=0 throughout.
  - scan_done single pulse one cycle after code 7 is pushed.
- Reset mid-scan: assert rst after the third scan push -> next cycle out_valid=0, scan_busy=0, no scan_done. A later scan_start restarts from y=8'h01.
- With DEC38_ACTIVE_LOW_EN defined: push code 2 -> y=8'hFB; idle y=8'hFF.
